register_file_multiport: RTL
============================

// Module: register_file_multiport
// PURPOSE
//  Parametrised MIPS general-purpose register file: DEPTH x N storage, NUM_RD read ports, one write port.
//  Supersedes the fixed 32:1 read mux. Adds an optional registered-read mode, write-to-read bypass and a hardwired zero register.
//  Sits in the ID stage. It takes rs/rt (and an optional third operand) and is written from WB.
// PARAMETERS
//  N         32   data width in bits
//  DEPTH     32   number of registers; power of 2, >= 2
//  NUM_RD    2    number of read ports, 1..4
//  RD_REG    0    0 = combinational read; 1 = read data registered, 1-cycle latency
//  BYPASS    1    1 = same-cycle write data forwarded to a matching read address
//  ZERO_REG  1    1 = register 0 reads 0 and ignores writes
// PORTS
//  clk               in   1              rising-edge clock
//  reset             in   1              asynchronous, active-high reset
//  in_WriteEnable    in   1              write strobe for the current cycle
//  in_WriteAddr      in   AW             write address; AW = $clog2(DEPTH)
//  in_WriteData      in   N              write data
//  in_ReadEnable     in   NUM_RD         per-port read strobe; used only when RD_REG=1
//  in_ReadAddr       in   NUM_RD*AW      packed read addresses; port p = [p*AW +: AW]
//  o_ReadData        out  NUM_RD*N       packed read data; port p = [p*N +: N]
//  o_ReadValid       out  NUM_RD         RD_REG=1: high the cycle after a strobed read; RD_REG=0: tied 1
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - all storage cleared to 0
//   - RD_REG=1: o_ReadData = 0 and o_ReadValid = 0
//   - reset asserted mid-write: the write is discarded
//  Write:
//   - on posedge clk with in_WriteEnable=1, mem[in_WriteAddr] <= in_WriteData
//   - ZERO_REG=1 and addr 0: write dropped; no state change
//  Read, RD_REG=0:
//   - o_ReadData[p] = mem[addr_p], purely combinational
//   - BYPASS=1 and WE && addr_p == in_WriteAddr && !(ZERO_REG && addr_p == 0): returns in_WriteData
//  Read, RD_REG=1:
//   - on posedge with in_ReadEnable[p]=1: o_ReadData[p] <= same selection as above
//     (bypassed value when BYPASS=1, old mem value otherwise); o_ReadValid[p] <= 1
//   - in_ReadEnable[p]=0: data held, o_ReadValid[p] <= 0
//  Read of address 0 with ZERO_REG=1 always returns 0, including under bypass.
//  Multiple ports on the same address: each returns the identical value; no port priority.
//  Addresses are AW bits wide, so no out-of-range case exists; there is no wrap logic.
//  No stalls and no back-pressure: one write and NUM_RD reads are accepted every cycle.
//  Outputs are never X after reset, for every address.
// STRUCTURE
//  Shared package mips_regfile_pkg:
//   - function clog2
//   - localparam REG_ZERO = 0
//   - default N / DEPTH constants
//  Sub-module regfile_read_port:
//   - one read path: DEPTH:1 select, bypass compare, zero mask, optional output register
//   - instantiated NUM_RD times in a generate loop
//  Storage: reg array with async-reset clear loop.
// TESTING
//  1. Assert reset 3 cycles, release -> every port reads 0 at every addr 0..31; RD_REG=1 also o_ReadValid = 0.
//  2. Write 0xDEADBEEF to r5, next cycle read r5 on both ports -> 0xDEADBEEF on both ports (RD_REG=1: one cycle later, valid = 1).
//  3. BYPASS=1: same cycle write r9 = 0x1234 and read r9 -> 0x1234 in that cycle.
//     BYPASS=0 -> old value 0, then 0x1234 the following cycle.
//  4. ZERO_REG=1: write r0 = 0xFFFFFFFF with read r0 in the same cycle -> 0 at once and 0 on every later read.
//  5. Assert reset asynchronously between edges while a write to r7 = 0xA5A5A5A5 is pending -> r7 reads 0 after release.
//  6. N=64, DEPTH=16, NUM_RD=3, RD_REG=1:
//     - random write/read for 10k cycles, checked against a reference model
//     - all 3 ports on the same address -> identical data

Source files
------------

// File: rtl/register_file_multiport_pkg.sv
// Shared constants and helpers for the MIPS general-purpose register file.
package mips_regfile_pkg;

  localparam int unsigned REG_ZERO  = 0;
  localparam int unsigned DEF_N     = 32;
  localparam int unsigned DEF_DEPTH = 32;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    int unsigned rem;
    res = 0;
    rem = value - 1;
    while (rem > 0) begin
      res = res + 1;
      rem = rem >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/register_file_multiport_if.sv
// Register-file access bundle: one write port plus NUM_RD packed read ports.
interface register_file_multiport_if #(
  parameter int unsigned N      = 32,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned NUM_RD = 2
);
  import mips_regfile_pkg::*;

  localparam int unsigned AW = clog2(DEPTH);

  logic                   write_enable;
  logic [AW-1:0]          write_addr;
  logic [N-1:0]           write_data;
  logic [NUM_RD-1:0]      read_enable;
  logic [NUM_RD*AW-1:0]   read_addr;
  logic [NUM_RD*N-1:0]    read_data;
  logic [NUM_RD-1:0]      read_valid;

  modport master (
    output write_enable, write_addr, write_data, read_enable, read_addr,
    input  read_data, read_valid
  );

  modport slave (
    input  write_enable, write_addr, write_data, read_enable, read_addr,
    output read_data, read_valid
  );

endinterface

// File: rtl/register_file_multiport_read_port.sv
// One read path: DEPTH:1 select, write bypass, zero-register mask, optional output register.
module regfile_read_port
  import mips_regfile_pkg::*;
#(
  parameter int unsigned N        = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned RD_REG   = 0,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned ZERO_REG = 1,
  localparam int unsigned AW      = clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DEPTH-1:0][N-1:0]   mem,
  input  logic                      write_enable,
  input  logic [AW-1:0]             write_addr,
  input  logic [N-1:0]              write_data,
  input  logic                      read_enable,
  input  logic [AW-1:0]             read_addr,
  output logic [N-1:0]              read_data,
  output logic                      read_valid
);

  logic [N-1:0] sel;

  // Zero mask is applied last so it also wins over a bypassed write.
  always_comb begin
    sel = mem[read_addr];
    if ((BYPASS != 0) && write_enable && (read_addr == write_addr)) begin
      sel = write_data;
    end
    if ((ZERO_REG != 0) && (read_addr == AW'(REG_ZERO))) begin
      sel = '0;
    end
  end

  if (RD_REG != 0) begin : g_reg
    logic [N-1:0] data_q;
    logic         valid_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= read_enable;
        if (read_enable) begin
          data_q <= sel;
        end
      end
    end

    assign read_data  = data_q;
    assign read_valid = valid_q;
  end else begin : g_comb
    logic unused_inputs;
    assign unused_inputs = ^{clk, reset, read_enable};
    assign read_data     = sel;
    assign read_valid    = 1'b1;
  end

endmodule

// File: rtl/register_file_multiport.sv
// Parametrised MIPS GPR file: DEPTH x N storage, one write port, NUM_RD read ports.
module register_file_multiport
  import mips_regfile_pkg::*;
#(
  parameter int unsigned N        = DEF_N,
  parameter int unsigned DEPTH    = DEF_DEPTH,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned RD_REG   = 0,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned ZERO_REG = 1
) (
  input logic                    clk,
  input logic                    reset,
  register_file_multiport_if.slave bus
);

  localparam int unsigned AW = clog2(DEPTH);

  logic [DEPTH-1:0][N-1:0] mem_q;
  logic                    write_ok;
  logic [NUM_RD*N-1:0]     rdata;
  logic [NUM_RD-1:0]       rvalid;

  assign write_ok = bus.write_enable &&
                    !((ZERO_REG != 0) && (bus.write_addr == AW'(REG_ZERO)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (write_ok) begin
      mem_q[bus.write_addr] <= bus.write_data;
    end
  end

  for (genvar p = 0; p < int'(NUM_RD); p++) begin : g_rd
    regfile_read_port #(
      .N        (N),
      .DEPTH    (DEPTH),
      .RD_REG   (RD_REG),
      .BYPASS   (BYPASS),
      .ZERO_REG (ZERO_REG)
    ) u_read_port (
      .clk          (clk),
      .reset        (reset),
      .mem          (mem_q),
      .write_enable (bus.write_enable),
      .write_addr   (bus.write_addr),
      .write_data   (bus.write_data),
      .read_enable  (bus.read_enable[p]),
      .read_addr    (bus.read_addr[p*AW +: AW]),
      .read_data    (rdata[p*N +: N]),
      .read_valid   (rvalid[p])
    );
  end

  assign bus.read_data  = rdata;
  assign bus.read_valid = rvalid;

endmodule
